sdram_burst_scheduler: RTL and testbench

SDRAM_BURST_SCHEDULER -- requirements
Module: sdram_burst_scheduler

---
 rtl/sdram_burst_scheduler.sv | 158 +++++++++++++++
 tb/tb_sdram_burst_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_scheduler.sv
// Arbitrates camera-write and VGA-read bursts to one SDRAM controller.
// Frame-start pulses switch the ping-pong banks between bursts.
module sdram_burst_scheduler #(
    parameter int BURST_LEN     = 256,
    parameter int FRAME_WORDS   = 786432,
    parameter int RD_LOW_WM     = 256,
    parameter int WR_STARVE_MAX = 4
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [9:0]  wr_fifo_level,
    input  logic [9:0]  rd_fifo_level,
    input  logic        wr_frame_start,
    input  logic        rd_frame_start,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [22:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_done,
    output logic        wr_grant,
    output logic        rd_grant
);
    localparam int SW = $clog2(WR_STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE_MAX);
    localparam logic [10:0]   RD_WM      = 11'(RD_LOW_WM);
    localparam logic [10:0]   BURST_11   = 11'(BURST_LEN);
    localparam logic [22:0]   BURST_23   = 23'(BURST_LEN);
    localparam logic [22:0]   FRAME_23   = 23'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t          state_q, state_d;
    logic            req_d, wr_d, wgnt_d, rgnt_d;
    logic [22:0]     addr_d;
    logic [21:0]     wr_off_q, wr_off_d, rd_off_q, rd_off_d;
    logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic            wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            wr_apply, rd_apply;
    logic            rd_need, wr_need;
    logic [22:0]     wr_off_inc, rd_off_inc;
    logic [21:0]     wr_off_next, rd_off_next;

    assign rd_need = ({1'b0, rd_fifo_level} < RD_WM);
    assign wr_need = ({1'b0, wr_fifo_level} >= BURST_11);

    // Offsets wrap to the start of the frame once the next burst would not fit
    assign wr_off_inc  = {1'b0, wr_off_q} + BURST_23;
    assign rd_off_inc  = {1'b0, rd_off_q} + BURST_23;
    assign wr_off_next = (wr_off_inc >= FRAME_23) ? '0 : wr_off_inc[21:0];
    assign rd_off_next = (rd_off_inc >= FRAME_23) ? '0 : rd_off_inc[21:0];

    always_comb begin
        state_d   = state_q;
        req_d     = mem_req;
        wr_d      = mem_wr;
        addr_d    = mem_addr;
        wgnt_d    = wr_grant;
        rgnt_d    = rd_grant;
        wr_off_d  = wr_off_q;
        rd_off_d  = rd_off_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        starve_d  = starve_q;
        wr_apply  = 1'b0;
        rd_apply  = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending frame start consumes the whole IDLE cycle; write side first
                if (wr_pend_q) begin
                    wr_apply  = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                    wr_off_d  = '0;
                    wr_pend_d = 1'b0;
                end else if (rd_pend_q) begin
                    rd_apply  = 1'b1;
                    rd_bank_d = ~wr_bank_q;
                    rd_off_d  = '0;
                    rd_pend_d = 1'b0;
                end else if (rd_need && (!wr_need || starve_q != STARVE_MAX)) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = {rd_bank_q, rd_off_q};
                    rgnt_d  = 1'b1;
                    if (wr_need && starve_q != STARVE_MAX)
                        starve_d = starve_q + SW'(1);
                end else if (wr_need) begin
                    state_d  = REQ;
                    req_d    = 1'b1;
                    wr_d     = 1'b1;
                    addr_d   = {wr_bank_q, wr_off_q};
                    wgnt_d   = 1'b1;
                    starve_d = '0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = BUSY;
                    req_d   = 1'b0;
                end
            end
            BUSY: begin
                if (mem_done) begin
                    state_d = IDLE;
                    wgnt_d  = 1'b0;
                    rgnt_d  = 1'b0;
                    if (wr_grant)
                        wr_off_d = wr_off_next;
                    else
                        rd_off_d = rd_off_next;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pulse landing in the cycle its flag is applied counts as already served
        if (wr_frame_start && !wr_apply)
            wr_pend_d = 1'b1;
        if (rd_frame_start && !rd_apply)
            rd_pend_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            wr_grant  <= 1'b0;
            rd_grant  <= 1'b0;
            wr_off_q  <= '0;
            rd_off_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b1;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            mem_req   <= req_d;
            mem_wr    <= wr_d;
            mem_addr  <= addr_d;
            wr_grant  <= wgnt_d;
            rd_grant  <= rgnt_d;
            wr_off_q  <= wr_off_d;
            rd_off_q  <= rd_off_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            starve_q  <= starve_d;
        end
    end
endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Scoreboard bench: a transaction-level model predicts every burst request,
// a monitor pops and compares, a responder plays the SDRAM controller.
module tb_sdram_burst_scheduler;
    localparam int BURST = 256;
    localparam int FRAME = 786432;
    localparam int WM    = 256;
    localparam int SMAX  = 4;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [9:0]  wr_fifo_level, rd_fifo_level;
    logic        wr_frame_start, rd_frame_start;
    logic        mem_req, mem_wr, mem_ack, mem_done, wr_grant, rd_grant;
    logic [22:0] mem_addr;

    sdram_burst_scheduler dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_done(mem_done),
        .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    always #5 clk_in = ~clk_in;

    int          total = 0;
    int          bad = 0;
    logic [23:0] exp_q[$];
    logic        grant_log[$];
    int          req_seen = 0;
    int          phase = 0;
    int          resp_cnt = 0;
    int          force_delay = -1;
    bit          fast = 1'b0;
    bit          hold_done = 1'b0;
    logic        prev_req = 1'b0;
    logic [23:0] cur = '0;

    int m_wr_off, m_rd_off, m_starve;
    bit m_wr_bank, m_rd_bank;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_wr_off = 0; m_rd_off = 0; m_starve = 0;
        m_wr_bank = 1'b0; m_rd_bank = 1'b1;
    endfunction

    function automatic int adv(int off);
        return (off + BURST >= FRAME) ? 0 : off + BURST;
    endfunction

    function automatic void model_frame(bit w, bit r);
        if (w) begin m_wr_bank = ~m_wr_bank; m_wr_off = 0; end
        if (r) begin m_rd_bank = ~m_wr_bank; m_rd_off = 0; end
    endfunction

    // One arbitration decision; returns 0 read, 1 write, -1 nothing
    function automatic int model_grant(int rl, int wl);
        bit rn = (rl < WM);
        bit wn = (wl >= BURST);
        if (rn && !(wn && m_starve == SMAX)) begin
            exp_q.push_back({1'b0, m_rd_bank, 22'(m_rd_off)});
            if (wn) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            m_rd_off = adv(m_rd_off);
            return 0;
        end
        if (wn) begin
            exp_q.push_back({1'b1, m_wr_bank, 22'(m_wr_off)});
            m_starve = 0;
            m_wr_off = adv(m_wr_off);
            return 1;
        end
        return -1;
    endfunction

    // Monitor: new request pops the scoreboard; held request must stay stable
    initial begin
        forever begin
            @(negedge clk_in);
            if (mem_req && !prev_req) begin
                req_seen++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_req: got wr=%0d addr=0x%0h required no request", mem_wr, mem_addr);
                end else begin
                    cur = exp_q.pop_front();
                    grant_log.push_back(mem_wr);
                    checkOutput("req_wr", 32'(mem_wr), 32'(cur[23]));
                    checkOutput("req_addr", 32'(mem_addr), 32'(cur[22:0]));
                    checkOutput("req_grant", 32'({wr_grant, rd_grant}), cur[23] ? 32'd2 : 32'd1);
                end
            end else if (mem_req) begin
                checkOutput("hold_wr", 32'(mem_wr), 32'(cur[23]));
                checkOutput("hold_addr", 32'(mem_addr), 32'(cur[22:0]));
            end
            prev_req = mem_req;
        end
    end

    // Controller model with random ack/done latency and stray done pulses during REQ
    initial begin
        mem_ack = 1'b0; mem_done = 1'b0;
        forever begin
            @(negedge clk_in);
            mem_ack = 1'b0; mem_done = 1'b0;
            if (!rst_n) begin
                phase = 0;
            end else begin
                if (phase == 0) begin
                    if (mem_req) begin
                        resp_cnt = fast ? 0 : (force_delay >= 0 ? force_delay : int'($urandom_range(0, 10)));
                        phase = 1;
                    end else begin
                        checkOutput("idle_grant", 32'({wr_grant, rd_grant}), 32'd0);
                    end
                end
                if (phase == 1) begin
                    if (!fast && $urandom_range(0, 3) == 0) mem_done = 1'b1;
                    if (resp_cnt == 0) begin
                        mem_ack  = 1'b1;
                        resp_cnt = fast ? 0 : int'($urandom_range(0, 3));
                        phase    = 2;
                    end else begin
                        resp_cnt--;
                    end
                end else if (phase == 2 && !hold_done) begin
                    if (resp_cnt == 0) begin
                        mem_done = 1'b1;
                        phase    = 0;
                    end else begin
                        resp_cnt--;
                    end
                end
            end
        end
    end

    task automatic park();
        rd_fifo_level = 10'd512;
        wr_fifo_level = 10'd0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(posedge clk_in); #2;
            if (phase == 0 && !mem_req) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            total++; bad++;
            $display("[TB] FAIL idle_timeout: got busy required idle within 400 cycles");
        end
    endtask

    task automatic wait_reqs(input int target, input int budget);
        for (int i = 0; i < budget && req_seen < target; i++) begin
            @(posedge clk_in); #2;
        end
        if (req_seen < target) begin
            total++; bad++;
            $display("[TB] FAIL req_timeout: got %0d requests required %0d", req_seen, target);
        end
    endtask

    // Hold levels for n arbitration rounds, then park the FIFOs so the DUT idles
    task automatic applyStimulus(input int rl, input int wl, input int n);
        int grants = 0;
        for (int k = 0; k < n; k++)
            if (model_grant(rl, wl) >= 0) grants++;
        rd_fifo_level = 10'(rl);
        wr_fifo_level = 10'(wl);
        if (grants > 0) wait_reqs(req_seen + grants, grants * 40 + 40);
        else repeat (8) @(posedge clk_in);
        #2;
        park();
        wait_idle();
    endtask

    task automatic pulse_frames(input bit w, input bit r, input bit dbl);
        wr_frame_start = w; rd_frame_start = r;
        @(posedge clk_in); #2;
        if (dbl) begin @(posedge clk_in); #2; end
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    endtask

    task automatic frame_op(input bit w, input bit r, input bit dbl);
        pulse_frames(w, r, dbl);
        repeat (4) @(posedge clk_in);
        #2;
        model_frame(w, r);
    endtask

    task automatic burst_with_frame(input int rl, input int wl, input bit w, input bit r, input bit dbl);
        if (model_grant(rl, wl) < 0) begin
            frame_op(w, r, dbl);
        end else begin
            rd_fifo_level = 10'(rl);
            wr_fifo_level = 10'(wl);
            wait_reqs(req_seen + 1, 80);
            park();
            pulse_frames(w, r, dbl);
            model_frame(w, r);
            wait_idle();
        end
    endtask

    task automatic reset_op();
        void'(model_grant(0, 0));
        hold_done = 1'b1;
        rd_fifo_level = 10'd0;
        wr_fifo_level = 10'd0;
        wait_reqs(req_seen + 1, 80);
        park();
        for (int i = 0; i < 50 && phase != 2; i++) @(posedge clk_in);
        @(posedge clk_in); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_req", 32'(mem_req), 32'd0);
        checkOutput("abort_wr", 32'(mem_wr), 32'd0);
        checkOutput("abort_addr", 32'(mem_addr), 32'd0);
        checkOutput("abort_grant", 32'({wr_grant, rd_grant}), 32'd0);
        model_reset();
        hold_done = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;
        rst_n = 1'b1;
        wait_idle();
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind, rl, wl;
        rst_n = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        park();
        model_reset();
        repeat (3) @(posedge clk_in);
        #2;
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_wr", 32'(mem_wr), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_grant", 32'({wr_grant, rd_grant}), 32'd0);
        rst_n = 1'b1;
        wait_idle();

        // First read request after reset: one cycle latency, bank 1 offset 0
        void'(model_grant(0, 0));
        rd_fifo_level = 10'd0; wr_fifo_level = 10'd0;
        checkOutput("req_pre", 32'(mem_req), 32'd0);
        @(posedge clk_in); #1;
        checkOutput("req_lat", 32'(mem_req), 32'd1);
        checkOutput("req_lat_addr", 32'(mem_addr), 32'h400000);
        park();
        wait_idle();

        // Both needs held: four reads then one write, twice
        fast = 1'b1;
        grant_log.delete();
        applyStimulus(100, 300, 10);
        checkOutput("order_len", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            checkOutput($sformatf("order_%0d", i), 32'(grant_log[i]), 32'(i % 5 == 4));
        fast = 1'b0;

        // Long ack stall with stray done pulses
        force_delay = 10;
        applyStimulus(0, 0, 1);
        applyStimulus(512, 400, 1);
        force_delay = -1;

        // Directed frame-start cases: merged pulses and write-before-read order
        frame_op(1'b1, 1'b0, 1'b1);
        frame_op(1'b1, 1'b1, 1'b0);
        frame_op(1'b1, 1'b1, 1'b1);
        burst_with_frame(512, 300, 1'b1, 1'b0, 1'b0);
        frame_op(1'b0, 1'b1, 1'b0);
        applyStimulus(0, 0, 2);
        applyStimulus(512, 300, 2);

        for (int op = 0; op < 60; op++) begin
            kind = int'($urandom_range(0, 9));
            rl = int'($urandom_range(0, 511));
            wl = int'($urandom_range(0, 511));
            if (kind <= 4)
                applyStimulus(rl, wl, int'($urandom_range(1, 8)));
            else if (kind <= 6)
                frame_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (kind <= 8)
                burst_with_frame(rl, wl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                reset_op();
        end

        // Enough consecutive writes to cross the end of the frame
        fast = 1'b1;
        applyStimulus(512, 300, 3075);
        fast = 1'b0;

        reset_op();
        applyStimulus(512, 300, 2);
        applyStimulus(0, 0, 2);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
